fetch_stage: RTL and testbench

- Instruction-fetch stage directly downstream of the PC updater.
- Takes the current PC and issues one read per instruction to a variable-latency instruction memory.
- Captures the returned word into the IF/ID pipeline register and pulses pc_advance so the PC updater steps to the next address.
- Handles decode stalls, branch flushes with an in-flight request, and HLT detection.

---
 rtl/fetch_stage_pkg.sv | 23 ++
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_stage_if_id_register.sv | 40 ++++
 rtl/fetch_stage.sv | 136 +++++++++++++
 tb/tb_fetch_stage.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants, opcode field and state encoding for the instruction-fetch stage.
// Pure declarations: no logic, no latency, no flow control.
package fetch_stage_pkg;

    localparam int                 INSTR_W    = 16;
    localparam logic [3:0]         HLT_OPCODE = 4'hF;
    localparam logic [INSTR_W-1:0] NOP_WORD   = 16'h0000;
    localparam int                 OP_MSB     = 15;
    localparam int                 OP_LSB     = 12;

    typedef enum logic [2:0] {
        START,
        FETCH,
        HOLD,
        DRAIN,
        HALTED
    } fetch_state_t;

    function automatic logic is_hlt(input logic [INSTR_W-1:0] word);
        return word[OP_MSB:OP_LSB] == HLT_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of PC, instruction-memory and IF/ID signals around the fetch stage.
// slave = fetch stage side; master = PC updater / memory / decode side.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic [INSTR_W-1:0] pc_in;
    logic               pc_advance;
    logic               mem_req;
    logic [INSTR_W-1:0] mem_addr;
    logic               mem_ready;
    logic [INSTR_W-1:0] mem_rdata;
    logic               stall;
    logic               flush;
    logic [INSTR_W-1:0] instr_out;
    logic [INSTR_W-1:0] pc_plus2_out;
    logic               instr_valid;
    logic               halted;

    modport master (
        output pc_in, mem_ready, mem_rdata, stall, flush,
        input  pc_advance, mem_req, mem_addr, instr_out, pc_plus2_out, instr_valid, halted
    );

    modport slave (
        input  pc_in, mem_ready, mem_rdata, stall, flush,
        output pc_advance, mem_req, mem_addr, instr_out, pc_plus2_out, instr_valid, halted
    );

endinterface

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register: instruction, PC+2 and valid; load, hold or clear each edge.
// One-edge latency; holds whenever neither load nor clear is asserted.
module if_id_register
    import fetch_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [INSTR_W-1:0] i_pc_plus2,
    output logic [INSTR_W-1:0] o_instr,
    output logic [INSTR_W-1:0] o_pc_plus2,
    output logic               o_valid
);

    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] r_pc_plus2;
    logic               r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr    <= NOP_WORD;
            r_pc_plus2 <= '0;
            r_valid    <= 1'b0;
        end else if (i_clear) begin
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr    <= i_instr;
            r_pc_plus2 <= i_pc_plus2;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus2 = r_pc_plus2;
    assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one memory read per instruction into IF/ID, pc_advance on accept.
// Response reaches IF/ID at the next edge; a stalled response parks in a one-entry hold buffer.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fetch_stage_if.slave bus
);

    fetch_state_t       r_state;
    logic               r_mem_req;
    logic               r_entry;
    logic               r_halted;
    logic [INSTR_W-1:0] r_req_addr;
    logic [INSTR_W-1:0] r_hold_instr;
    logic [INSTR_W-1:0] r_hold_pc2;

    logic               w_free;
    logic               w_load;
    logic               w_clear;
    logic               w_adv;
    logic [INSTR_W-1:0] w_addr;
    logic [INSTR_W-1:0] w_ld_instr;
    logic [INSTR_W-1:0] w_ld_pc2;

    // First FETCH cycle presents pc_in directly; later cycles replay the latched copy.
    assign w_addr = r_entry ? bus.pc_in : r_req_addr;
    assign w_free = !bus.instr_valid || !bus.stall;

    always_comb begin
        w_load     = 1'b0;
        w_ld_instr = bus.mem_rdata;
        w_ld_pc2   = w_addr + INSTR_W'(2);
        if (!bus.flush && w_free) begin
            if (r_state == FETCH && bus.mem_ready) begin
                w_load = 1'b1;
            end else if (r_state == HOLD) begin
                w_load     = 1'b1;
                w_ld_instr = r_hold_instr;
                w_ld_pc2   = r_hold_pc2;
            end
        end
    end

    assign w_adv   = w_load && !is_hlt(w_ld_instr);
    // Decode consumes a valid entry whenever it is not stalled, so an unreplaced entry becomes a bubble.
    assign w_clear = bus.flush || (!bus.stall && !w_load);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= START;
            r_mem_req    <= 1'b0;
            r_entry      <= 1'b0;
            r_halted     <= 1'b0;
            r_req_addr   <= '0;
            r_hold_instr <= '0;
            r_hold_pc2   <= '0;
        end else begin
            r_entry <= 1'b0;
            case (r_state)
                START: begin
                    r_state   <= FETCH;
                    r_mem_req <= 1'b1;
                    r_entry   <= 1'b1;
                end
                FETCH: begin
                    r_req_addr <= w_addr;
                    if (bus.flush) begin
                        if (bus.mem_ready) r_entry <= 1'b1;
                        else               r_state <= DRAIN;
                    end else if (bus.mem_ready) begin
                        if (!w_free) begin
                            r_hold_instr <= bus.mem_rdata;
                            r_hold_pc2   <= w_ld_pc2;
                            r_state      <= HOLD;
                            r_mem_req    <= 1'b0;
                        end else if (!w_adv) begin
                            r_state   <= HALTED;
                            r_mem_req <= 1'b0;
                            r_halted  <= 1'b1;
                        end else begin
                            r_entry <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.flush || w_adv) begin
                        r_state   <= FETCH;
                        r_mem_req <= 1'b1;
                        r_entry   <= 1'b1;
                    end else if (w_load) begin
                        r_state  <= HALTED;
                        r_halted <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.mem_ready) begin
                        r_state <= FETCH;
                        r_entry <= 1'b1;
                    end
                end
                HALTED: begin
                    if (bus.flush) begin
                        r_state   <= FETCH;
                        r_mem_req <= 1'b1;
                        r_entry   <= 1'b1;
                        r_halted  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= START;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    if_id_register u_if_id (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_clear   (w_clear),
        .i_instr   (w_ld_instr),
        .i_pc_plus2(w_ld_pc2),
        .o_instr   (bus.instr_out),
        .o_pc_plus2(bus.pc_plus2_out),
        .o_valid   (bus.instr_valid)
    );

    assign bus.pc_advance = w_adv;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_addr   = w_addr;
    assign bus.halted     = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: PC updater and variable-latency memory models around the DUT,
// directed scenarios plus a randomized stall/latency run against a program-order model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        set_pc  = 1'b0;
    logic [15:0] set_val = '0;
    logic [15:0] pc      = '0;
    int          lat     = 1;
    int          mcnt    = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    fetch_stage_if bus();

    fetch_stage dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Memory image: two fixed words, everything else a unique non-HLT pattern.
    function automatic logic [15:0] memword(input logic [15:0] a);
        if (a == 16'h0000) return 16'hA123;
        if (a == 16'h0040) return 16'hF000;
        return {1'b0, a[15:1]} ^ 16'h3C5A;
    endfunction

    // PC updater and memory latency counter.
    always @(posedge clk) begin
        if (set_pc)              pc <= set_val;
        else if (bus.pc_advance) pc <= pc + 16'd2;
        if (!bus.mem_req || bus.mem_ready) mcnt <= 0;
        else                               mcnt <= mcnt + 1;
    end

    assign bus.pc_in     = pc;
    assign bus.mem_ready = bus.mem_req && (mcnt >= lat - 1);
    assign bus.mem_rdata = memword(bus.mem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ends in the first FETCH cycle with pc_in = p.
    task automatic restart(input logic [15:0] p, input int l);
        rst = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
        set_pc = 1'b1; set_val = p; lat = l;
        tick(); tick();
        set_pc = 1'b0; rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
        set_pc = 1'b1; set_val = 16'h0000; lat = 1;
        tick(); tick();
        @(negedge clk);
        n_checks++; if ({bus.mem_req, bus.pc_advance, bus.instr_valid, bus.halted} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {bus.mem_req, bus.pc_advance, bus.instr_valid, bus.halted}); end
        n_checks++; if (bus.instr_out !== NOP_WORD) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", bus.instr_out, NOP_WORD); end
        n_checks++; if (bus.pc_plus2_out !== 16'h0000) begin n_fail++; $display("FAIL reset_pc2: got %h expected 0000", bus.pc_plus2_out); end
        n_checks++; if (bus.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h expected 0000", bus.mem_addr); end
    endtask

    task automatic test_back_to_back();
        tick();
        set_pc = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL start_req: got %b expected 0", bus.mem_req); end
        tick(); @(negedge clk);
        n_checks++; if ({bus.mem_req, bus.pc_advance} !== 2'b11) begin n_fail++; $display("FAIL b2b_first_req_adv: got %b expected 11", {bus.mem_req, bus.pc_advance}); end
        n_checks++; if (bus.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL b2b_first_addr: got %h expected 0000", bus.mem_addr); end
        tick(); @(negedge clk);
        n_checks++; if (bus.instr_out !== 16'hA123 || bus.pc_plus2_out !== 16'h0002 || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_ifid0: got %h/%h/%b expected a123/0002/1", bus.instr_out, bus.pc_plus2_out, bus.instr_valid); end
        n_checks++; if (bus.mem_addr !== 16'h0002 || bus.pc_advance !== 1'b1) begin n_fail++; $display("FAIL b2b_second_req: got %h/%b expected 0002/1", bus.mem_addr, bus.pc_advance); end
        tick(); @(negedge clk);
        n_checks++; if (bus.instr_out !== memword(16'h0002) || bus.pc_plus2_out !== 16'h0004) begin n_fail++; $display("FAIL b2b_ifid1: got %h/%h expected %h/0004", bus.instr_out, bus.pc_plus2_out, memword(16'h0002)); end
    endtask

    task automatic test_latency();
        int advs = 0;
        restart(16'h0010, 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.pc_advance) advs++;
            n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0010) begin n_fail++; $display("FAIL lat_addr_hold[%0d]: got %b/%h expected 1/0010", i, bus.mem_req, bus.mem_addr); end
            tick();
        end
        n_checks++; if (advs !== 1) begin n_fail++; $display("FAIL lat_adv_count: got %0d expected 1", advs); end
        @(negedge clk);
        n_checks++; if (bus.instr_out !== memword(16'h0010) || bus.pc_plus2_out !== 16'h0012) begin n_fail++; $display("FAIL lat_ifid: got %h/%h expected %h/0012", bus.instr_out, bus.pc_plus2_out, memword(16'h0010)); end
    endtask

    task automatic test_stall_hold();
        restart(16'h0030, 2);
        tick(); tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (bus.instr_out !== memword(16'h0030) || bus.pc_plus2_out !== 16'h0032 || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_ifid_hold[%0d]: got %h/%h/%b expected %h/0032/1", i, bus.instr_out, bus.pc_plus2_out, bus.instr_valid, memword(16'h0030)); end
            n_checks++; if (bus.pc_advance !== 1'b0) begin n_fail++; $display("FAIL stall_no_adv[%0d]: got %b expected 0", i, bus.pc_advance); end
            if (i >= 2) begin
                n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req[%0d]: got %b expected 0", i, bus.mem_req); end
            end
            tick();
        end
        bus.stall = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.pc_advance !== 1'b1) begin n_fail++; $display("FAIL hold_release_adv: got %b expected 1", bus.pc_advance); end
        tick(); @(negedge clk);
        n_checks++; if (bus.instr_out !== memword(16'h0032) || bus.pc_plus2_out !== 16'h0034) begin n_fail++; $display("FAIL hold_ifid: got %h/%h expected %h/0034", bus.instr_out, bus.pc_plus2_out, memword(16'h0032)); end
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0034) begin n_fail++; $display("FAIL hold_resume_req: got %b/%h expected 1/0034", bus.mem_req, bus.mem_addr); end
        tick(); tick(); @(negedge clk);
        n_checks++; if (bus.instr_out !== memword(16'h0034) || bus.pc_plus2_out !== 16'h0036) begin n_fail++; $display("FAIL hold_next_ifid: got %h/%h expected %h/0036", bus.instr_out, bus.pc_plus2_out, memword(16'h0034)); end
    endtask

    task automatic test_flush_drain();
        restart(16'h0020, 2);
        bus.flush = 1'b1; set_pc = 1'b1; set_val = 16'h0100;
        @(negedge clk);
        n_checks++; if (bus.pc_advance !== 1'b0 || bus.mem_addr !== 16'h0020) begin n_fail++; $display("FAIL flush_cycle: got adv %b addr %h expected 0/0020", bus.pc_advance, bus.mem_addr); end
        tick();
        bus.flush = 1'b0; set_pc = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0020 || bus.pc_advance !== 1'b0) begin n_fail++; $display("FAIL drain_req: got %b/%h/%b expected 1/0020/0", bus.mem_req, bus.mem_addr, bus.pc_advance); end
        n_checks++; if (bus.instr_valid !== 1'b0 || bus.instr_out !== NOP_WORD) begin n_fail++; $display("FAIL drain_ifid: got %b/%h expected 0/%h", bus.instr_valid, bus.instr_out, NOP_WORD); end
        tick(); @(negedge clk);
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0100 || bus.pc_advance !== 1'b0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_req: got %b/%h/%b/%b expected 1/0100/0/0", bus.mem_req, bus.mem_addr, bus.pc_advance, bus.instr_valid); end
        tick(); tick(); @(negedge clk);
        n_checks++; if (bus.instr_out !== memword(16'h0100) || bus.pc_plus2_out !== 16'h0102) begin n_fail++; $display("FAIL redirect_ifid: got %h/%h expected %h/0102", bus.instr_out, bus.pc_plus2_out, memword(16'h0100)); end
    endtask

    task automatic test_halt();
        restart(16'h0040, 1);
        @(negedge clk);
        n_checks++; if (bus.pc_advance !== 1'b0) begin n_fail++; $display("FAIL hlt_adv: got %b expected 0", bus.pc_advance); end
        tick(); @(negedge clk);
        n_checks++; if (bus.halted !== 1'b1 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL hlt_state: got halted %b req %b expected 1/0", bus.halted, bus.mem_req); end
        n_checks++; if (bus.instr_out !== 16'hF000 || bus.pc_plus2_out !== 16'h0042 || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL hlt_ifid: got %h/%h/%b expected f000/0042/1", bus.instr_out, bus.pc_plus2_out, bus.instr_valid); end
        repeat (3) begin
            tick(); @(negedge clk);
            n_checks++; if (bus.halted !== 1'b1 || bus.mem_req !== 1'b0 || bus.pc_advance !== 1'b0) begin n_fail++; $display("FAIL hlt_idle: got %b/%b/%b expected 1/0/0", bus.halted, bus.mem_req, bus.pc_advance); end
        end
        tick();
        bus.flush = 1'b1; set_pc = 1'b1; set_val = 16'h0080;
        tick();
        bus.flush = 1'b0; set_pc = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.halted !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0080 || bus.pc_advance !== 1'b1) begin n_fail++; $display("FAIL hlt_resume: got %b/%b/%h/%b expected 0/1/0080/1", bus.halted, bus.mem_req, bus.mem_addr, bus.pc_advance); end
        tick(); @(negedge clk);
        n_checks++; if (bus.instr_out !== memword(16'h0080) || bus.pc_plus2_out !== 16'h0082) begin n_fail++; $display("FAIL hlt_resume_ifid: got %h/%h expected %h/0082", bus.instr_out, bus.pc_plus2_out, memword(16'h0080)); end
    endtask

    task automatic test_wrap();
        restart(16'hFFFE, 1);
        @(negedge clk);
        n_checks++; if (bus.mem_addr !== 16'hFFFE || bus.pc_advance !== 1'b1) begin n_fail++; $display("FAIL wrap_req: got %h/%b expected fffe/1", bus.mem_addr, bus.pc_advance); end
        tick(); @(negedge clk);
        n_checks++; if (bus.instr_out !== memword(16'hFFFE) || bus.pc_plus2_out !== 16'h0000 || bus.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_ifid: got %h/%h addr %h expected %h/0000/0000", bus.instr_out, bus.pc_plus2_out, bus.mem_addr, memword(16'hFFFE)); end
        tick(); @(negedge clk);
        n_checks++; if (bus.instr_out !== 16'hA123 || bus.pc_plus2_out !== 16'h0002) begin n_fail++; $display("FAIL wrap_next: got %h/%h expected a123/0002", bus.instr_out, bus.pc_plus2_out); end
    endtask

    task automatic test_reset_mid();
        restart(16'h0020, 3);
        bus.flush = 1'b1; set_pc = 1'b1; set_val = 16'h0200;
        tick();
        bus.flush = 1'b0; set_pc = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_checks++; if ({bus.mem_req, bus.pc_advance, bus.instr_valid, bus.halted} !== 4'b0000 || bus.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_drain: got %b addr %h expected 0000/0000", {bus.mem_req, bus.pc_advance, bus.instr_valid, bus.halted}, bus.mem_addr); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_start_req: got %b expected 0", bus.mem_req); end
        tick(); @(negedge clk);
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0200) begin n_fail++; $display("FAIL rst_refetch: got %b/%h expected 1/0200", bus.mem_req, bus.mem_addr); end
        restart(16'h0040, 1);
        tick(); @(negedge clk);
        n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL rst_pre_halt: got %b expected 1", bus.halted); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (bus.halted !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instr_out !== NOP_WORD || bus.pc_plus2_out !== 16'h0000) begin n_fail++; $display("FAIL rst_halted: got %b/%b/%h/%h expected 0/0/%h/0000", bus.halted, bus.instr_valid, bus.instr_out, bus.pc_plus2_out, NOP_WORD); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] start, exp_cons, exp_fetch, prev_addr, prev_instr, prev_pc2;
        logic        prev_wait, prev_hold;
        int          cons, advs;
        cons = 0; advs = 0; prev_wait = 1'b0; prev_hold = 1'b0;
        prev_addr = '0; prev_instr = '0; prev_pc2 = '0;
        start = 16'h1000 + 16'(2 * $urandom_range(0, 2047));
        restart(start, 1);
        exp_cons  = start;
        exp_fetch = start;
        for (int c = 0; c < 400; c++) begin
            bus.stall = (c < 380) && ($urandom_range(0, 3) == 0);
            lat = (c < 380) ? int'($urandom_range(1, 3)) : 1000;
            @(negedge clk);
            if (bus.pc_advance) advs++;
            if (prev_wait && bus.mem_req) begin
                n_checks++; if (bus.mem_addr !== prev_addr) begin n_fail++; $display("FAIL rnd_addr_stable c%0d: got %h expected %h", c, bus.mem_addr, prev_addr); end
            end
            if (bus.mem_req && bus.mem_ready) begin
                n_checks++; if (bus.mem_addr !== exp_fetch) begin n_fail++; $display("FAIL rnd_fetch_addr c%0d: got %h expected %h", c, bus.mem_addr, exp_fetch); end
                exp_fetch = exp_fetch + 16'd2;
            end
            if (prev_hold) begin
                n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== prev_instr || bus.pc_plus2_out !== prev_pc2) begin n_fail++; $display("FAIL rnd_stall_hold c%0d: got %b/%h/%h expected 1/%h/%h", c, bus.instr_valid, bus.instr_out, bus.pc_plus2_out, prev_instr, prev_pc2); end
            end
            if (bus.instr_valid && !bus.stall) begin
                n_checks++; if (bus.instr_out !== memword(exp_cons) || bus.pc_plus2_out !== exp_cons + 16'd2) begin n_fail++; $display("FAIL rnd_consume c%0d: got %h/%h expected %h/%h", c, bus.instr_out, bus.pc_plus2_out, memword(exp_cons), exp_cons + 16'd2); end
                exp_cons = exp_cons + 16'd2;
                cons++;
            end
            prev_wait  = bus.mem_req && !bus.mem_ready;
            prev_addr  = bus.mem_addr;
            prev_hold  = bus.instr_valid && bus.stall;
            prev_instr = bus.instr_out;
            prev_pc2   = bus.pc_plus2_out;
            tick();
        end
        n_checks++; if (advs !== cons) begin n_fail++; $display("FAIL rnd_adv_vs_consumed: got %0d advances expected %0d", advs, cons); end
        n_checks++; if (cons < 60) begin n_fail++; $display("FAIL rnd_throughput: got %0d instructions expected at least 60", cons); end
        n_checks++; if (pc !== start + 16'(2 * cons)) begin n_fail++; $display("FAIL rnd_final_pc: got %h expected %h", pc, start + 16'(2 * cons)); end
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        test_reset();
        test_back_to_back();
        test_latency();
        test_stall_hold();
        test_flush_drain();
        test_halt();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
